pwl_share_arbiter: RTL
======================

// Module: pwl_share_arbiter
// PURPOSE
//  Shares one sqrt->rsqrt PWL pipeline (valid/ready, in-order, 16-bit) among N_REQ requesters.
//  Round-robin selection; one registered issue stage drives the pipe.
//  A tag FIFO of requester IDs steers each in-order result back to its owner.
//  Sits between the normalisation clients and the single PWL pipeline instance.
// PARAMETERS
//  N_REQ      4   number of requesters (2..8); ID_W = clog2(N_REQ) is a localparam
//  DATA_W     16  x / y operand width
//  TAG_DEPTH  8   max outstanding ops incl. issue register; power of 2, >=2
// PORTS
//  clk             in   1             clock
//  rst             in   1             synchronous, active-high reset
//  req_valid       in   N_REQ         per-requester operand valid
//  req_ready       out  N_REQ         per-requester accept (one-hot or zero)
//  req_x           in   N_REQ*DATA_W  packed operands; requester i at [i*DATA_W +: DATA_W]
//  rsp_valid       out  N_REQ         result valid, one-hot to the owning requester
//  rsp_ready       in   N_REQ         per-requester result accept
//  rsp_y           out  DATA_W        result data, shared by all requesters
//  pwl_in_valid    out  1             to pipe: operand valid (registered)
//  pwl_in_ready    in   1             from pipe
//  pwl_x           out  DATA_W        to pipe: operand (registered)
//  pwl_out_valid   in   1             from pipe: result valid
//  pwl_out_ready   out  1             to pipe: result accept
//  pwl_y           in   DATA_W        from pipe: result
//  outstanding     out  ID_W'..       $clog2(TAG_DEPTH+1) bits; ops accepted but not yet returned
//  err_orphan      out  1             sticky: pipe produced a result with no tag outstanding
// BEHAVIOUR
//  Reset: pwl_in_valid=0, pwl_x=0, rr_ptr=0, FIFO rd/wr ptr=0, outstanding=0, err_orphan=0.
//   In-flight ops are discarded. The pipe is reset from the same rst.
//  can_load = (~pwl_in_valid | pwl_in_ready) & (outstanding < TAG_DEPTH).
//   A full FIFO blocks loading even if a pop occurs in the same cycle.
//  Grant (comb.): first i with req_valid[i], scanning from rr_ptr upward mod N_REQ.
//   req_ready = can_load ? onehot(grant) : 0; req_ready never depends on req_ready.
//  On accept of requester g:
//   - pwl_x <= req_x[g]; pwl_in_valid <= 1
//   - push tag g into FIFO
//   - rr_ptr <= (g+1) mod N_REQ
//  No accept while pwl_in_valid & pwl_in_ready: pwl_in_valid <= 0.
//  Issue latency: accept in cycle T -> pwl_in_valid=1 in cycle T+1; x held stable until pwl_in_ready.
//  Throughput: 1 op/cycle while the pipe is ready and the FIFO is not full.
//  Return path (head tag h, FIFO non-empty):
//   - rsp_valid = pwl_out_valid ? onehot(h) : 0; rsp_y = pwl_y
//   - pwl_out_ready = rsp_ready[h]
//   - pop when pwl_out_valid & rsp_ready[h]
//  Results are strictly in issue order. A stalled head blocks all later results (head-of-line).
//  Orphan (pwl_out_valid & FIFO empty):
//   - pwl_out_ready=1 (drain), no rsp_valid, err_orphan <= 1 until rst
//  outstanding = push - pop, updated every cycle. Push and pop in the same cycle leave it unchanged.
//  FIFO ptrs are log2(TAG_DEPTH)+1 bits: full when MSBs differ and LSBs are equal; wrap is natural.
// CONFIGURATION
//  PWL_ARB_PRIO0_EN defined: requester 0 has strict priority.
//   - It is granted whenever req_valid[0] & can_load.
//   - rr_ptr advances only on grants to requesters 1..N_REQ-1, scanning them round-robin.
//  PWL_ARB_PRIO0_EN undefined: pure round-robin over all requesters as above.
// TESTING
//  1 Single op: req_valid=4'b0100, req_x[2]=16'h4000, pipe model y=16'h1234
//    -> req_ready=4'b0100; pwl_x=16'h4000 next cycle; later rsp_valid=4'b0100, rsp_y=16'h1234.
//  2 Fairness: all 4 req_valid held, pipe always ready
//    -> grant order 0,1,2,3,0,1,..; 4 accepts per 4 cycles; responses match tags.
//  3 Full: pwl_out_valid held 0
//    -> 8 accepts, then outstanding=8 and req_ready=0;
//    -> one result popped -> exactly one new accept the following cycle.
//  4 Head-of-line: head tag=1, rsp_ready[1]=0, rsp_ready[0]=1
//    -> pwl_out_ready=0, rsp_y stable, no pop; raising rsp_ready[1] pops 1 then delivers tag 0.
//  5 Orphan: pwl_out_valid=1 with outstanding=0
//    -> pwl_out_ready=1, rsp_valid=0, err_orphan=1 and stays 1.
//  6 Reset mid-run: rst=1 for 1 cycle with 3 outstanding and pwl_in_valid=1
//    -> next cycle pwl_in_valid=0, outstanding=0, err_orphan=0, first grant scans from 0.
//  7 PWL_ARB_PRIO0_EN: req 0 and 3 held valid -> req 0 granted every cycle; req 3 starves.
//    Macro off: the same stimulus alternates 0,3,0,3.

Source files
------------

// File: rtl/pwl_share_arbiter.sv
// pwl_share_arbiter: shares one in-order sqrt->rsqrt PWL pipeline among N_REQ
// requesters. Round-robin grant feeds a single registered issue stage, and a
// tag FIFO of requester IDs steers each in-order result back to its owner.
// Optional build macro PWL_ARB_PRIO0_EN gives requester 0 strict priority;
// leave it undefined for pure round-robin over all requesters.
module pwl_share_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*DATA_W-1:0]         req_x,
  output logic [N_REQ-1:0]                rsp_valid,
  input  logic [N_REQ-1:0]                rsp_ready,
  output logic [DATA_W-1:0]               rsp_y,
  output logic                            pwl_in_valid,
  input  logic                            pwl_in_ready,
  output logic [DATA_W-1:0]               pwl_x,
  input  logic                            pwl_out_valid,
  output logic                            pwl_out_ready,
  input  logic [DATA_W-1:0]               pwl_y,
  output logic [$clog2(TAG_DEPTH+1)-1:0]  outstanding,
  output logic                            err_orphan
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW    = $clog2(TAG_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(TAG_DEPTH);

`ifdef PWL_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  rr_next;
  logic             grant_any;
  logic             can_load;
  logic             accept;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
  logic [ID_W-1:0]  head_id;
  logic             fifo_empty;
  logic             pop;

  // A full tag FIFO blocks loading even when a pop lands in the same cycle.
  assign can_load = (~pwl_in_valid | pwl_in_ready) & (outstanding < DEPTH_CNT);
  assign accept   = can_load & grant_any;
  assign rr_next  = ID_W'((int'(grant_id) + 1) % N_REQ);

  // Grant: first valid requester scanning upward from rr_ptr; in priority
  // mode requester 0 is excluded from the scan and overrides it when valid.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!grant_any && req_valid[idx] && !(PRIO0 && idx == 0)) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    if (PRIO0 && req_valid[0]) begin
      grant_any = 1'b1;
      grant_id  = '0;
    end
  end

  // Accept is one-hot to the granted requester, only when the issue stage can load.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Issue register: captures the granted operand and holds it until the pipe takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwl_in_valid <= 1'b0;
      pwl_x        <= '0;
    end else if (accept) begin
      pwl_in_valid <= 1'b1;
      pwl_x        <= req_x[int'(grant_id)*DATA_W +: DATA_W];
    end else if (pwl_in_ready) begin
      pwl_in_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past each grantee; requester 0 does not move it in priority mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && (!PRIO0 || grant_id != '0)) begin
      rr_ptr <= rr_next;
    end
  end

  // Tag storage: requester ID of each accepted op, written at the tail on accept.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr[AW-1:0]] <= grant_id;
  end

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign head_id    = tag_mem[rd_ptr[AW-1:0]];
  assign pop        = pwl_out_valid & ~fifo_empty & rsp_ready[head_id];
  assign rsp_y      = pwl_y;

  // Return steering: head tag owns the result; with no tag the pipe is drained as an orphan.
  always_comb begin
    rsp_valid     = '0;
    pwl_out_ready = 1'b1;
    if (!fifo_empty) begin
      pwl_out_ready = rsp_ready[head_id];
      if (pwl_out_valid) rsp_valid[head_id] = 1'b1;
    end
  end

  // FIFO pointers and outstanding count; a push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky flag: the pipe returned a result while no tag was outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (pwl_out_valid && fifo_empty) begin
      err_orphan <= 1'b1;
    end
  end

endmodule
